// File: rtl/adder_test_pkg.sv
// Shared constants and state encoding for the adder test-vector generator.
package adder_test_pkg;

  localparam int WIDTH_DEFAULT = 6;
  localparam int N_PATTERNS    = 1 << (2 * WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_vec_checker.sv
// Compares the adder response with the expected sum on each accepted vector;
// keeps a saturating mismatch count and captures the first failing index.
module adder_vec_checker
  import adder_test_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 2 * WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [WIDTH:0]       exp_i,
  input  logic [WIDTH:0]       got_i,
  input  logic [2*WIDTH-1:0]   idx_i,
  output logic [CNT_W-1:0]     error_count_o,
  output logic [2*WIDTH-1:0]   first_err_index_o,
  output logic                 err_flag_o
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] first_q, first_d;
  logic               flag_q, flag_d;
  logic               mismatch;

  assign mismatch = en_i && (got_i != exp_i);

  always_comb begin
    cnt_d   = cnt_q;
    first_d = first_q;
    flag_d  = flag_q;
    if (clear_i) begin
      cnt_d   = '0;
      first_d = '0;
      flag_d  = 1'b0;
    end else if (mismatch) begin
      // Saturate instead of wrapping so a huge failure count never reads as small.
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      if (!flag_q) begin
        first_d = idx_i;
        flag_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      first_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
      flag_q  <= flag_d;
    end
  end

  assign error_count_o     = cnt_q;
  assign first_err_index_o = first_q;
  assign err_flag_o        = flag_q;

endmodule

// File: rtl/adder_vector_gen.sv
// Sweeps every {x, y} operand pair in x-major order into an adder and checks
// each response. Handshake: a vector transfers on any cycle with valid && ready.
module adder_vector_gen
  import adder_test_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 2 * WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ready,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic                 valid,
  output logic [WIDTH-1:0]     x,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH:0]       s_exp,
  output logic [2*WIDTH-1:0]   index,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     error_count,
  output logic [2*WIDTH-1:0]   first_err_index,
  output logic                 err_flag,
  output logic [1:0]           state_o
);

  localparam int IDX_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               accept;
  logic               sweep_start;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    accept      = 1'b0;
    sweep_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          index_d     = '0;
          sweep_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (ready) begin
          accept = 1'b1;
          // The last index is held so the final vector stays visible in DONE.
          if (index_q == {IDX_W{1'b1}}) state_d = ST_DONE;
          else                          index_d = index_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  assign valid   = (state_q == ST_RUN);
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign index   = index_q;
  assign x       = index_q[IDX_W-1:WIDTH];
  assign y       = index_q[WIDTH-1:0];
  assign s_exp   = {1'b0, x} + {1'b0, y};
  assign state_o = state_q;

  adder_vec_checker #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_checker (
    .clk               (clk),
    .rst               (rst),
    .clear_i           (sweep_start),
    .en_i              (accept),
    .exp_i             (s_exp),
    .got_i             ({dut_cout, dut_s}),
    .idx_i             (index_q),
    .error_count_o     (error_count),
    .first_err_index_o (first_err_index),
    .err_flag_o        (err_flag)
  );

endmodule
